// File: rtl/string_hw_pkg.sv
// Shared constants, state encoding and helpers for the string accelerator
// Avalon-MM front end.
package string_hw_pkg;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_LEN    = 3'd5;

  localparam int CTRL_START_BIT = 8;
  localparam int CTRL_IRQEN_BIT = 9;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;
  localparam int STAT_TO_BIT   = 3;

  localparam int LEN_A_LSB = 0;
  localparam int LEN_B_LSB = 8;

  localparam logic [2:0] OP_CMP   = 3'd0;
  localparam logic [2:0] OP_UPPER = 3'd1;
  localparam logic [2:0] OP_LOWER = 3'd2;

  localparam logic [2:0] LEN_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DROP
  } state_t;

  // Operands hold at most four characters, so larger lengths clamp to four.
  function automatic logic [2:0] satLen(input logic [2:0] value);
    return (value > LEN_MAX) ? LEN_MAX : value;
  endfunction

endpackage

// File: rtl/string_hw_avalon_if.sv
// Avalon-MM slave bus bundle between the interconnect and the string
// accelerator front end.
interface string_hw_avalon_if;

  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  read,
    output readdata,
    output irq
  );

  modport master (
    output address,
    output write,
    output writedata,
    output read,
    input  readdata,
    input  irq
  );

endinterface

// File: rtl/string_hw_watchdog.sv
// Go-to-done watchdog: cleared when an operation starts, counts edges while
// enabled and flags expiry on the edge that completes TIMEOUT_CYCLES.
module string_hw_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of edges already spent, so the current edge is the last one.
  assign o_expired = i_count && (r_count == LAST);

endmodule

// File: rtl/string_hw_avalon.sv
// Avalon-MM slave front end that sequences the string accelerator's go/done
// handshake and reports completion through sticky status bits and an irq.
module string_hw_avalon
  import string_hw_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  string_hw_avalon_if.slave  avs,
  output logic               go,
  output logic [2:0]         index,
  output logic [31:0]        A,
  output logic [31:0]        B,
  output logic [2:0]         lengthA,
  output logic [2:0]         lengthB,
  input  logic               done,
  input  logic [31:0]        result
);

  state_t r_state;
  state_t w_nextState;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic [31:0] r_readdata;
  logic [2:0]  r_index;
  logic [2:0]  r_lenA;
  logic [2:0]  r_lenB;
  logic        r_irqEn;
  logic        r_statDone;
  logic        r_statErr;
  logic        r_statTo;

  logic        w_busy;
  logic        w_inIssue;
  logic        w_wrA;
  logic        w_wrB;
  logic        w_wrCtrl;
  logic        w_wrLen;
  logic        w_wrStatus;
  logic        w_start;
  logic        w_startWhileBusy;
  logic        w_capture;
  logic        w_timeout;
  logic        w_dropDone;
  logic        w_expired;
  logic [31:0] w_readMux;

  // Operand, control and length writes are gated by busy so the core sees stable inputs.
  assign w_wrA            = avs.write && (avs.address == ADDR_A) && !w_busy;
  assign w_wrB            = avs.write && (avs.address == ADDR_B) && !w_busy;
  assign w_wrLen          = avs.write && (avs.address == ADDR_LEN) && !w_busy;
  assign w_wrCtrl         = avs.write && (avs.address == ADDR_CTRL);
  assign w_wrStatus       = avs.write && (avs.address == ADDR_STATUS);
  assign w_start          = w_wrCtrl && avs.writedata[CTRL_START_BIT] && !w_busy;
  assign w_startWhileBusy = w_wrCtrl && avs.writedata[CTRL_START_BIT] && w_busy;
  assign w_capture        = w_inIssue && done;
  assign w_timeout        = w_inIssue && !done && w_expired;
  assign w_dropDone       = (r_state == DROP) && !done;

  string_hw_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start),
    .i_count  (w_inIssue),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_nextState = ISSUE;
      ISSUE:   if (done || w_expired) w_nextState = DROP;
      DROP:    if (!done) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    go        = (r_state == ISSUE);
    w_inIssue = (r_state == ISSUE);
    w_busy    = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_index <= '0;
      r_irqEn <= 1'b0;
      r_lenA  <= '0;
      r_lenB  <= '0;
    end else begin
      if (w_wrA) r_a <= avs.writedata;
      if (w_wrB) r_b <= avs.writedata;
      if (w_wrCtrl && !w_busy) begin
        r_index <= avs.writedata[2:0];
        r_irqEn <= avs.writedata[CTRL_IRQEN_BIT];
      end
      if (w_wrLen) begin
        r_lenA <= satLen(avs.writedata[LEN_A_LSB +: 3]);
        r_lenB <= satLen(avs.writedata[LEN_B_LSB +: 3]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
    end else if (w_capture) begin
      r_result <= result;
    end
  end

  // Sticky status bits: a hardware set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_statDone <= 1'b0;
      r_statErr  <= 1'b0;
      r_statTo   <= 1'b0;
    end else begin
      if (w_dropDone) begin
        r_statDone <= 1'b1;
      end else if (w_wrStatus && avs.writedata[STAT_DONE_BIT]) begin
        r_statDone <= 1'b0;
      end
      if (w_startWhileBusy || w_timeout) begin
        r_statErr <= 1'b1;
      end else if (w_wrStatus && avs.writedata[STAT_ERR_BIT]) begin
        r_statErr <= 1'b0;
      end
      if (w_timeout) begin
        r_statTo <= 1'b1;
      end else if (w_wrStatus && avs.writedata[STAT_TO_BIT]) begin
        r_statTo <= 1'b0;
      end
    end
  end

  always_comb begin
    w_readMux = '0;
    unique case (avs.address)
      ADDR_A:      w_readMux = r_a;
      ADDR_B:      w_readMux = r_b;
      ADDR_CTRL:   w_readMux = {22'd0, r_irqEn, 1'b0, 5'd0, r_index};
      ADDR_RESULT: w_readMux = r_result;
      ADDR_STATUS: w_readMux = {28'd0, r_statTo, r_statErr, r_statDone, w_busy};
      ADDR_LEN:    w_readMux = {21'd0, r_lenB, 5'd0, r_lenA};
      default:     w_readMux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (avs.read) begin
      r_readdata <= w_readMux;
    end
  end

  assign avs.readdata = r_readdata;
  assign avs.irq      = r_irqEn & r_statDone;
  assign index        = r_index;
  assign A            = r_a;
  assign B            = r_b;
  assign lengthA      = r_lenA;
  assign lengthB      = r_lenB;

endmodule

// File: tb/tb_string_hw_avalon.sv
// Self-checking bench for string_hw_avalon with a behavioural accelerator core
// and a string-level reference model.
module tb_string_hw_avalon;
  import string_hw_pkg::*;

  logic        clk;
  logic        reset;
  logic        go;
  logic [2:0]  index;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  lengthA;
  logic [2:0]  lengthB;
  logic        done;
  logic [31:0] result;

  int nChecks;
  int nErrors;
  int goPulses;
  int goHighCycles;
  bit stuck;
  int fixedLat;

  string_hw_avalon_if bus ();

  string_hw_avalon #(.TIMEOUT_CYCLES(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .avs    (bus),
    .go     (go),
    .index  (index),
    .A      (A),
    .B      (B),
    .lengthA(lengthA),
    .lengthB(lengthB),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge go) goPulses++;
  always @(negedge clk) if (go) goHighCycles++;

  // String semantics of the accelerator: case-sensitive compare, or case conversion of the first len chars.
  function automatic logic [31:0] accelOp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic [2:0] la,
                                          input logic [2:0] lb);
    logic [31:0] r;
    logic [7:0]  c;
    bit          eq;
    r = a;
    if (op == OP_CMP) begin
      eq = (la == lb);
      for (int i = 0; i < int'(la); i++)
        if (a[31-8*i -: 8] != b[31-8*i -: 8]) eq = 1'b0;
      r = {31'd0, eq};
    end else begin
      for (int i = 0; i < int'(la); i++) begin
        c = a[31-8*i -: 8];
        if (op == OP_UPPER && c >= 8'h61 && c <= 8'h7A) c = c - 8'd32;
        if (op == OP_LOWER && c >= 8'h41 && c <= 8'h5A) c = c + 8'd32;
        r[31-8*i -: 8] = c;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] clampLen(input int v);
    return (v > 4) ? 3'd4 : 3'(v);
  endfunction

  // Behavioural accelerator core: raises done a few cycles after go, drops it after go falls.
  initial begin : accelModel
    int waitCnt;
    int target;
    done    = 1'b0;
    result  = '0;
    waitCnt = 0;
    target  = 1;
    forever begin
      @(negedge clk);
      if (!go) begin
        waitCnt = 0;
        done    = 1'b0;
      end else if (!done && !stuck && index <= 3'd2) begin
        if (waitCnt == 0) target = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
        waitCnt++;
        if (waitCnt >= target) begin
          result = accelOp(A, B, index, lengthA, lengthB);
          done   = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address   = addr;
    bus.writedata = data;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address = addr;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
    data        = bus.readdata;
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      readReg(ADDR_STATUS, s);
      n++;
    end while (s[STAT_BUSY_BIT] && n < 400);
    checkOutput({tag, "_idle"}, {31'd0, s[STAT_BUSY_BIT]}, 32'd0);
  endtask

  initial begin : stimulus
    logic [31:0] rd;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expRes;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  op;
    logic [2:0]  la;
    logic [2:0]  lb;
    int          rla;
    int          rlb;
    int          ie;
    int          pulses0;
    int          high0;

    nChecks       = 0;
    nErrors       = 0;
    goPulses      = 0;
    goHighCycles  = 0;
    stuck         = 1'b0;
    fixedLat      = 0;
    bus.address   = '0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    bus.read      = 1'b0;
    reset         = 1'b1;

    #12;
    checkOutput("rst_go", {31'd0, go}, 32'd0);
    checkOutput("rst_readdata", bus.readdata, 32'd0);
    checkOutput("rst_irq", {31'd0, bus.irq}, 32'd0);
    checkOutput("rst_A", A, 32'd0);
    checkOutput("rst_lens", {26'd0, lengthB, lengthA}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    readReg(ADDR_RESULT, rd);  checkOutput("rst_result", rd, 32'd0);
    readReg(ADDR_STATUS, rd);  checkOutput("rst_status", rd, 32'd0);

    $display("[TB] directed: to-upper");
    expA = 32'h61624344;
    applyStimulus(ADDR_A, expA);
    applyStimulus(ADDR_LEN, 32'h0404);
    applyStimulus(ADDR_CTRL, 32'h101);
    waitIdle("upper");
    readReg(ADDR_RESULT, rd);  checkOutput("upper_result", rd, 32'h41424344);
    readReg(ADDR_STATUS, rd);  checkOutput("upper_status", rd, 32'h2);
    checkOutput("upper_irq", {31'd0, bus.irq}, 32'd0);
    readReg(ADDR_CTRL, rd);    checkOutput("upper_ctrl", rd, 32'h001);

    $display("[TB] directed: to-lower with irq");
    expA = 32'h41622D5A;
    applyStimulus(ADDR_A, expA);
    applyStimulus(ADDR_CTRL, 32'h302);
    waitIdle("lower");
    readReg(ADDR_RESULT, rd);  checkOutput("lower_result", rd, 32'h61622D7A);
    readReg(ADDR_STATUS, rd);  checkOutput("lower_status", rd, 32'h2);
    checkOutput("lower_irq", {31'd0, bus.irq}, 32'd1);
    applyStimulus(ADDR_STATUS, 32'h2);
    readReg(ADDR_STATUS, rd);  checkOutput("w1c_status", rd, 32'h0);
    checkOutput("w1c_irq", {31'd0, bus.irq}, 32'd0);

    $display("[TB] directed: compare");
    expA = 32'h74657374;
    expB = 32'h74657374;
    applyStimulus(ADDR_A, expA);
    applyStimulus(ADDR_B, expB);
    applyStimulus(ADDR_CTRL, 32'h100);
    waitIdle("cmp_eq");
    readReg(ADDR_RESULT, rd);  checkOutput("cmp_eq_result", rd, 32'h1);
    expB = 32'h74657375;
    applyStimulus(ADDR_B, expB);
    applyStimulus(ADDR_CTRL, 32'h100);
    waitIdle("cmp_ne");
    readReg(ADDR_RESULT, rd);  checkOutput("cmp_ne_result", rd, 32'h0);

    $display("[TB] directed: writes while busy");
    applyStimulus(ADDR_STATUS, 32'hE);
    fixedLat = 20;
    pulses0  = goPulses;
    applyStimulus(ADDR_CTRL, 32'h101);
    applyStimulus(ADDR_CTRL, 32'h101);
    applyStimulus(ADDR_A, 32'hFFFFFFFF);
    waitIdle("busy");
    fixedLat = 0;
    readReg(ADDR_STATUS, rd);  checkOutput("busy_status", rd, 32'h6);
    readReg(ADDR_A, rd);       checkOutput("busy_A", rd, expA);
    checkOutput("busy_pulses", 32'(goPulses - pulses0), 32'd1);
    readReg(ADDR_RESULT, rd);  checkOutput("busy_result", rd, accelOp(expA, expB, OP_UPPER, 3'd4, 3'd4));
    expRes = rd;

    $display("[TB] directed: watchdog timeout");
    applyStimulus(ADDR_STATUS, 32'hE);
    stuck = 1'b1;
    high0 = goHighCycles;
    applyStimulus(ADDR_CTRL, 32'h101);
    waitIdle("timeout");
    checkOutput("timeout_go_cycles", 32'(goHighCycles - high0), 32'd64);
    readReg(ADDR_STATUS, rd);  checkOutput("timeout_status", rd, 32'hE);
    readReg(ADDR_RESULT, rd);  checkOutput("timeout_result", rd, expRes);
    stuck = 1'b0;

    $display("[TB] directed: unsupported opcode");
    applyStimulus(ADDR_STATUS, 32'hE);
    applyStimulus(ADDR_CTRL, 32'h103);
    waitIdle("badop");
    readReg(ADDR_STATUS, rd);  checkOutput("badop_status", rd, 32'hE);
    readReg(ADDR_CTRL, rd);    checkOutput("badop_ctrl", rd, 32'h003);

    $display("[TB] directed: length saturation and unmapped addresses");
    applyStimulus(ADDR_LEN, 32'h0707);
    readReg(ADDR_LEN, rd);     checkOutput("len_sat", rd, 32'h0404);
    applyStimulus(3'd6, 32'hFFFFFFFF);
    readReg(3'd6, rd);         checkOutput("addr6_read", rd, 32'h0);
    readReg(3'd7, rd);         checkOutput("addr7_read", rd, 32'h0);

    $display("[TB] directed: reset during ISSUE");
    stuck = 1'b1;
    applyStimulus(ADDR_CTRL, 32'h101);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_go", {31'd0, go}, 32'd0);
    checkOutput("midrst_A", A, 32'd0);
    checkOutput("midrst_index", {29'd0, index}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;
    readReg(ADDR_RESULT, rd);  checkOutput("midrst_result", rd, 32'h0);
    readReg(ADDR_STATUS, rd);  checkOutput("midrst_status", rd, 32'h0);
    readReg(ADDR_LEN, rd);     checkOutput("midrst_len", rd, 32'h0);
    applyStimulus(ADDR_A, 32'h61626364);
    applyStimulus(ADDR_LEN, 32'h0004);
    applyStimulus(ADDR_CTRL, 32'h101);
    waitIdle("postrst");
    readReg(ADDR_RESULT, rd);  checkOutput("postrst_result", rd, 32'h41424344);
    readReg(ADDR_STATUS, rd);  checkOutput("postrst_status", rd, 32'h2);

    $display("[TB] randomized operations");
    for (int t = 0; t < 24; t++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? ra : $urandom;
      rla = int'($urandom_range(0, 7));
      rlb = ($urandom_range(0, 1) == 1) ? rla : int'($urandom_range(0, 7));
      op  = 3'($urandom_range(0, 2));
      ie  = int'($urandom_range(0, 1));
      la  = clampLen(rla);
      lb  = clampLen(rlb);
      applyStimulus(ADDR_A, ra);
      applyStimulus(ADDR_B, rb);
      applyStimulus(ADDR_LEN, 32'((rlb << 8) | rla));
      applyStimulus(ADDR_STATUS, 32'hE);
      applyStimulus(ADDR_CTRL, 32'((ie << 9) | (1 << 8) | int'(op)));
      waitIdle("rand");
      expRes = accelOp(ra, rb, op, la, lb);
      readReg(ADDR_RESULT, rd);  checkOutput("rand_result", rd, expRes);
      readReg(ADDR_STATUS, rd);  checkOutput("rand_status", rd, 32'h2);
      checkOutput("rand_irq", {31'd0, bus.irq}, 32'(ie));
      readReg(ADDR_LEN, rd);     checkOutput("rand_len", rd, {21'd0, lb, 5'd0, la});
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/string_hw_avalon.md
# string_hw_avalon

Avalon-MM slave front end that drives the string accelerator's go/done handshake from the Nios II side. It holds the operand, length and control registers, sequences go, waits for done and captures the result. It then releases go, waits for done to drop, and reports completion through a sticky status bit and an optional interrupt. It sits between the Avalon interconnect and the accelerator core; the core is instantiated beside it at system level.

## Interface
- TIMEOUT_CYCLES, 64: cycles allowed from go assertion to done before the operation is aborted.
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- address  in  3  Avalon word address.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- read  in  1  Avalon read strobe.
- readdata  out  32  read data, registered, valid one cycle after read.
- irq  out  1  interrupt, level.
- go  out  1  accelerator start request.
- index  out  3  operation code (0 compare, 1 to-upper, 2 to-lower).
- A, B  out  32 each  operands; bits[31:24] are character 0.
- lengthA, lengthB  out  3 each  operand lengths, 0..4.
- done  in  1  accelerator completion.
- result  in  32  accelerator result, same byte order as A.

## Operation
- Register map (word address):
  - 0 A: RW.
  - 1 B: RW.
  - 2 CTRL:
    - [2:0] index, RW.
    - [8] start, write-only, reads 0.
    - [9] irq_en, RW.
  - 3 RESULT: RO.
  - 4 STATUS:
    - [0] busy, RO.
    - [1] done, sticky.
    - [2] error, sticky.
    - [3] timeout, sticky.
    - Bits [3:1] are write-1-to-clear.
  - 5 LEN:
    - [2:0] lengthA, RW.
    - [10:8] lengthB, RW.
    - Written values >4 saturate to 4.
  - Addresses 6-7 read 0; writes to them are ignored.
- A, B, index and LEN registers drive the accelerator ports directly.
- While busy, writes to A, B, LEN and CTRL are ignored, so operands stay stable.
- CTRL write with start=1 while busy sets error and does not restart the operation.
- FSM states:
  - IDLE: go=0. A CTRL write with start=1 latches index and irq_en and moves to ISSUE.
  - ISSUE: go=1, watchdog counts. When done=1, capture result into RESULT and move to DROP. If the watchdog expires first, set error and timeout and move to DROP without capturing.
  - DROP: go=0. When done=0, set STATUS.done, clear busy and move to IDLE.
- busy = (state != IDLE).
- irq = irq_en & STATUS.done.
- If a W1C write and a hardware set hit the same bit in the same cycle, the set wins.
- The accelerator must be in its idle state when start is issued. An index value of 3..7 is passed through unchanged; the core self-resets and done never rises, so the watchdog recovers.

## Timing
- Reset values: readdata=0, irq=0, go=0, index=0, A=B=0, lengths=0, RESULT=0, STATUS=0, state=IDLE.
- Asserting reset mid-operation drops go asynchronously and discards any pending result.
- The start write is accepted at edge n; go is high from n+1.
- RESULT is captured on the first edge where done=1 in ISSUE; go falls on the following cycle.
- STATUS.done and irq assert on the edge where done=0 is sampled in DROP.
- The watchdog counts edges in ISSUE. It expires when the count reaches TIMEOUT_CYCLES with done still 0.
- Read latency is 1 cycle; there is no waitrequest.

## Structure
- Package string_hw_pkg holds:
  - register address constants;
  - CTRL/STATUS bit positions;
  - op codes OP_CMP=0, OP_UPPER=1, OP_LOWER=2;
  - state enum {IDLE, ISSUE, DROP}.
- Sub-module string_hw_watchdog: load/count/expire counter parameterised by TIMEOUT_CYCLES. The register file and FSM stay inline.

## Test plan
- Write A=0x61624344 ("abCD"), LEN=0x0404, CTRL=0x101; poll STATUS -> RESULT=0x41424344, STATUS=0x2, irq=0.
- Write A=0x41622D5A, CTRL=0x302 -> RESULT=0x61622D7A, STATUS=0x2, irq=1. Then write STATUS=0x2 -> STATUS=0x0, irq=0.
- Write A=B=0x74657374, CTRL=0x100 -> RESULT=0x00000001. Then change B to 0x74657375 and start again -> RESULT=0x00000000.
- While busy, write CTRL=0x101 and A=0xFFFFFFFF -> STATUS.error=1, A readback unchanged, exactly one go pulse.
- Model done stuck at 0 and write CTRL=0x101 -> go drops after 64 cycles, STATUS=0xE, RESULT unchanged.
- Assert reset while in ISSUE -> go=0 immediately, all registers 0; the next start completes normally.
